// File: rtl/cpu_stage_seq.sv
// Multicycle control sequencer for the riscv32 custom_cpu.
// Walks each instruction through IF/IW/ID/EX/(ST|LD/RDW)/WB. It drives the
// instruction and data memory handshakes and the writeback completion pulse.
// Optional performance counters are enabled with `define CPU_SEQ_PERF_CNT_EN.
module cpu_stage_seq #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Inst_Req_Ready,
    input  logic             Inst_Valid,
    input  logic             Mem_Req_Ready,
    input  logic             Read_data_Valid,
    input  logic             dec_nop,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_rf_wen,
    output logic             Inst_Req_Valid,
    output logic             Inst_Ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Read_data_Ready,
    output logic             IR_wen,
    output logic             PC_wen,
    output logic             complete_wb,
    output logic [8:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned STATE_W = 9;

    typedef enum logic [STATE_W-1:0] {
        S_INIT = 9'h001,
        S_IF   = 9'h002,
        S_IW   = 9'h004,
        S_ID   = 9'h008,
        S_EX   = 9'h010,
        S_ST   = 9'h020,
        S_LD   = 9'h040,
        S_RDW  = 9'h080,
        S_WB   = 9'h100
    } state_e;

    state_e state_q;
    state_e state_d;

    assign state = state_q;

    // State register; reset parks the sequencer in INIT so every output decodes to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; IR_wen and the NOP PC_wen also look at the input they qualify.
    always_comb begin
        state_d         = S_INIT;
        Inst_Req_Valid  = 1'b0;
        Inst_Ready      = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        Read_data_Ready = 1'b0;
        IR_wen          = 1'b0;
        PC_wen          = 1'b0;
        complete_wb     = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                Inst_Req_Valid = 1'b1;
                state_d        = Inst_Req_Ready ? S_IW : S_IF;
            end
            S_IW: begin
                Inst_Ready = 1'b1;
                IR_wen     = Inst_Valid;
                state_d    = Inst_Valid ? S_ID : S_IW;
            end
            S_ID: begin
                PC_wen  = dec_nop;
                state_d = dec_nop ? S_IF : S_EX;
            end
            S_EX: begin
                PC_wen = 1'b1;
                if (dec_load) begin
                    state_d = S_LD;
                end else if (dec_store) begin
                    state_d = S_ST;
                end else if (dec_rf_wen) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ST: begin
                MemWrite = 1'b1;
                state_d  = Mem_Req_Ready ? S_IF : S_ST;
            end
            S_LD: begin
                MemRead = 1'b1;
                state_d = Mem_Req_Ready ? S_RDW : S_LD;
            end
            S_RDW: begin
                Read_data_Ready = 1'b1;
                state_d         = Read_data_Valid ? S_WB : S_RDW;
            end
            S_WB: begin
                complete_wb = 1'b1;
                state_d     = S_IF;
            end
            default: state_d = S_INIT;
        endcase
    end

`ifdef CPU_SEQ_PERF_CNT_EN
    logic             retire_c;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] retire_cnt_q;

    // An instruction retires in WB, on an accepted store, on EX straight back to IF, or on a NOP in ID.
    always_comb begin
        retire_c = 1'b0;
        case (state_q)
            S_WB:    retire_c = 1'b1;
            S_ST:    retire_c = Mem_Req_Ready;
            S_EX:    retire_c = !dec_load && !dec_store && !dec_rf_wen;
            S_ID:    retire_c = dec_nop;
            default: retire_c = 1'b0;
        endcase
    end

    // Free-running cycle and retire counters, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (retire_c) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_stage_seq.sv
// Directed, table-driven bench for cpu_stage_seq plus a hand-written mid-load reset sequence.
module tb_cpu_stage_seq;

    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid;
    logic             dec_nop, dec_load, dec_store, dec_rf_wen;
    logic             Inst_Req_Valid, Inst_Ready, MemRead, MemWrite, Read_data_Ready;
    logic             IR_wen, PC_wen, complete_wb;
    logic [8:0]       state;
    logic [CNT_W-1:0] cycle_cnt, retire_cnt;

    cpu_stage_seq #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Inst_Valid      (Inst_Valid),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data_Valid (Read_data_Valid),
        .dec_nop         (dec_nop),
        .dec_load        (dec_load),
        .dec_store       (dec_store),
        .dec_rf_wen      (dec_rf_wen),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Ready      (Inst_Ready),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .Read_data_Ready (Read_data_Ready),
        .IR_wen          (IR_wen),
        .PC_wen          (PC_wen),
        .complete_wb     (complete_wb),
        .state           (state),
        .cycle_cnt       (cycle_cnt),
        .retire_cnt      (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {rst, Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid, dec_nop, dec_load, dec_store, dec_rf_wen}
    // out = {Inst_Req_Valid, Inst_Ready, MemRead, MemWrite, Read_data_Ready, IR_wen, PC_wen, complete_wb}
    typedef struct packed {
        logic [8:0] in;
        logic [8:0] st;
        logic [7:0] out;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_fail;

    task automatic add(input logic [8:0] in, input logic [8:0] st, input logic [7:0] out);
        vec_t v;
        v.in  = in;
        v.st  = st;
        v.out = out;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] in);
        {rst, Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid,
         dec_nop, dec_load, dec_store, dec_rf_wen} = in;
    endtask

    function automatic logic [7:0] outs();
        return {Inst_Req_Valid, Inst_Ready, MemRead, MemWrite, Read_data_Ready,
                IR_wen, PC_wen, complete_wb};
    endfunction

    initial begin
        logic [31:0] exp_cyc;
        logic [31:0] exp_ret;
        n_vec  = 0;
        n_fail = 0;
        drive(9'b0_0000_0000);

        // Reset held 3 cycles, release, then walk ALU, NOP, store, load-with-stalls, branch.
        add(9'b0_0000_0000, 9'h001, 8'b0000_0000);
        add(9'b0_0000_0000, 9'h001, 8'b0000_0000);
        add(9'b0_0000_0000, 9'h001, 8'b0000_0000);
        add(9'b1_0000_0000, 9'h001, 8'b0000_0000);
        add(9'b1_0000_0000, 9'h002, 8'b1000_0000); // IF, no ready: hold
        add(9'b1_1001_0000, 9'h002, 8'b1000_0000); // IF, ready (+spurious rd valid)
        add(9'b1_0000_0000, 9'h004, 8'b0100_0000); // IW wait
        add(9'b1_0100_0000, 9'h004, 8'b0100_0100); // IW capture
        add(9'b1_0000_0000, 9'h008, 8'b0000_0000); // ID
        add(9'b1_0000_0001, 9'h010, 8'b0000_0010); // EX, ALU writes rd
        add(9'b1_0000_0000, 9'h100, 8'b0000_0001); // WB pulse
        add(9'b1_1000_0000, 9'h002, 8'b1000_0000);
        add(9'b1_0100_0000, 9'h004, 8'b0100_0100);
        add(9'b1_0000_1000, 9'h008, 8'b0000_0010); // ID NOP -> IF
        add(9'b1_1000_0000, 9'h002, 8'b1000_0000);
        add(9'b1_0100_0000, 9'h004, 8'b0100_0100);
        add(9'b1_0000_0000, 9'h008, 8'b0000_0000);
        add(9'b1_0000_0010, 9'h010, 8'b0000_0010); // EX store
        add(9'b1_0000_0000, 9'h020, 8'b0001_0000); // ST wait
        add(9'b1_0010_0000, 9'h020, 8'b0001_0000); // ST accepted -> IF
        add(9'b1_1000_0000, 9'h002, 8'b1000_0000);
        add(9'b1_0100_0000, 9'h004, 8'b0100_0100);
        add(9'b1_0000_0000, 9'h008, 8'b0000_0000);
        add(9'b1_0000_0110, 9'h010, 8'b0000_0010); // EX load+store: load wins
        add(9'b1_0000_0000, 9'h040, 8'b0010_0000); // LD stall 1
        add(9'b1_0000_0000, 9'h040, 8'b0010_0000); // LD stall 2
        add(9'b1_0000_0000, 9'h040, 8'b0010_0000); // LD stall 3
        add(9'b1_0010_0000, 9'h040, 8'b0010_0000); // LD accepted
        add(9'b1_0000_0000, 9'h080, 8'b0000_1000); // RDW stall 1
        add(9'b1_0000_0000, 9'h080, 8'b0000_1000); // RDW stall 2
        add(9'b1_0001_0000, 9'h080, 8'b0000_1000); // RDW data
        add(9'b1_0000_0000, 9'h100, 8'b0000_0001); // WB pulse
        add(9'b1_0001_0000, 9'h002, 8'b1000_0000); // spurious rd valid in IF
        add(9'b1_1000_0000, 9'h002, 8'b1000_0000);
        add(9'b1_0100_0000, 9'h004, 8'b0100_0100);
        add(9'b1_0000_0000, 9'h008, 8'b0000_0000);
        add(9'b1_0000_0000, 9'h010, 8'b0000_0010); // EX branch -> IF
        add(9'b1_0000_0000, 9'h002, 8'b1000_0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in);
            #2;
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].out));
`ifndef CPU_SEQ_PERF_CNT_EN
            chk($sformatf("vec%0d_cyc_zero", i), cycle_cnt, 32'd0);
`endif
        end

        // After the walk: 5 retirements; 34 clocked edges with reset released.
`ifdef CPU_SEQ_PERF_CNT_EN
        exp_ret = 32'd5;
        exp_cyc = 32'd34;
`else
        exp_ret = 32'd0;
        exp_cyc = 32'd0;
`endif
        chk("retire_after_walk", retire_cnt, exp_ret);
        chk("cycle_after_walk", cycle_cnt, exp_cyc);

        // Mid-load async reset: bring the FSM into LD with the request pending.
        @(negedge clk); drive(9'b1_1000_0000); // IF -> IW
        @(negedge clk); drive(9'b1_0100_0000); // IW -> ID
        @(negedge clk); drive(9'b1_0000_0000); // ID -> EX
        @(negedge clk); drive(9'b1_0000_0100); // EX -> LD
        @(negedge clk); drive(9'b1_0000_0000);
        #2;
        chk("ld_pending_memread", 32'(MemRead), 32'd1);
        chk("ld_pending_state", 32'(state), 32'h040);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_memread", 32'(MemRead), 32'd0);
        chk("async_rst_state", 32'(state), 32'h001);
        chk("async_rst_cycle", cycle_cnt, 32'd0);
        chk("async_rst_retire", retire_cnt, 32'd0);
        chk("async_rst_complete", 32'(complete_wb), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d_outs", k), 32'(outs()), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("post_rst_state", 32'(state), 32'h002);
        chk("post_rst_req", 32'(Inst_Req_Valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
